uart_rx_v2: RTL and testbench

//   8N1 UART receiver: serial -> parallel. Counterpart of uart_tx_v2.
//   - SoC side: samples SoC io_uart_txd for bench/host loopback.
//   - FPGA side: host-facing RX front end.
//   - Received bytes queue in a small first-word-fall-through FIFO with valid/rd_en pop.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_v2.sv | 119 +++++++++++
 tb/tb_uart_rx_v2.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and the receiver state encoding.
package uart_pkg;
  localparam int CLK_HZ           = 50_000_000;
  localparam int BAUD             = 115200;
  localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with a registered head output.
// The head register always mirrors mem[rdPtr] one cycle after any push or pop.
module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wrPtr, rdPtr, rdNext;
  logic [W-1:0] mem [DEPTH];
  logic         doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign rdNext = rdPtr + (AW+1)'(doPop);

  // Storage write; no reset needed, contents are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  end

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      rdPtr <= rdNext;
    end
  end

  // Head register: bypass din when the incoming byte becomes the new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (doPush || doPop) begin
      if (doPush && (rdNext[AW-1:0] == wrPtr[AW-1:0])) dout <= din;
      else                                             dout <= mem[rdNext[AW-1:0]];
    end
  end
endmodule

// File: rtl/uart_rx_v2.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, error pulses and
// a small byte FIFO toward the consumer.
module uart_rx_v2
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_p,
  output logic [7:0] dout,
  output logic       rx_valid,
  input  logic       rd_en,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);
  localparam int           CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t state;
  logic          rxMeta, rxS;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shreg;
  logic          cntDone, stopSample, pushReq;
  logic          fifoFull, fifoEmpty;

  assign cntDone    = (cnt == CNT_LAST);
  assign stopSample = (state == STOP) && cntDone;
  assign pushReq    = stopSample && rxS;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx_p;
      rxS    <= rxMeta;
    end
  end

  // Frame FSM: find start edge, confirm at half bit, then sample every bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxS) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt    <= '0;
            bitIdx <= '0;
            state  <= rxS ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cntDone) begin
            cnt    <= '0;
            shreg  <= {rxS, shreg[7:1]};
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cntDone) begin
            cnt   <= '0;
            state <= rxS ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          // Line may be held low (break); wait for it to return high.
          if (rxS) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-cycle status pulses from the stop-bit outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stopSample && !rxS;
      overrun   <= pushReq && fifoFull && !rd_en;
    end
  end

  assign rx_valid = !fifoEmpty;
  assign rx_busy  = (state != IDLE);

  uart_rx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushReq),
    .din   (shreg),
    .pop   (rd_en),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .dout  (dout)
  );
endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed bench for uart_rx_v2: serial driver, byte scoreboard, flag monitors.
module tb_uart_rx_v2;
  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxP = 1'b1;
  logic       rdEn = 1'b0;
  logic [7:0] dout;
  logic       rxValid, rxBusy, frameErr, overrun;

  int checks = 0;
  int errors = 0;
  int feCnt = 0;
  int ovCnt = 0;
  int busyCnt = 0;
  logic [7:0] expQ[$];

  uart_rx_v2 #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_p      (rxP),
    .dout      (dout),
    .rx_valid  (rxValid),
    .rd_en     (rdEn),
    .rx_busy   (rxBusy),
    .frame_err (frameErr),
    .overrun   (overrun)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pop the DUT performs is compared against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (frameErr) feCnt++;
      if (overrun)  ovCnt++;
      if (rxBusy)   busyCnt++;
      if (rxValid && rdEn) begin
        if (expQ.size() == 0) check("pop_underflow", 32'(dout), 32'hFFFF_FFFF);
        else                  check("rx_byte", 32'(dout), 32'(expQ.pop_front()));
      end
    end
  end

  task automatic bitTime();
    repeat (CPB) @(posedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopVal);
    rxP = 1'b0;
    bitTime();
    for (int i = 0; i < 8; i++) begin
      rxP = b[i];
      bitTime();
    end
    rxP = stopVal;
    bitTime();
    rxP = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("reset_outputs", {dout, rxValid, rxBusy, frameErr, overrun}, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(20);

    // 1: back-to-back bytes, consumer always ready
    rdEn = 1'b1;
    for (int b = 8'h41; b <= 8'h46; b++) begin
      expQ.push_back(8'(b));
      sendByte(8'(b), 1'b1);
    end
    idle(CPB);
    check("t1_all_received", expQ.size(), 0);
    check("t1_no_frame_err", feCnt, 0);
    check("t1_no_overrun", ovCnt, 0);

    // 2: short low glitch on an idle line
    busyCnt = 0;
    rxP = 1'b0;
    idle(100);
    rxP = 1'b1;
    idle(600);
    check("t2_busy_short", (busyCnt > 0) && (busyCnt < 220), 1);
    check("t2_idle_again", rxBusy, 0);
    check("t2_no_valid", rxValid, 0);
    check("t2_no_flags", feCnt + ovCnt, 0);

    // 3: stop bit low, line held low afterwards, then a good byte
    sendByte(8'h55, 1'b0);
    rxP = 1'b0;
    idle(2000);
    check("t3_frame_err_once", feCnt, 1);
    check("t3_busy_while_low", rxBusy, 1);
    check("t3_no_push", rxValid, 0);
    rxP = 1'b1;
    idle(10);
    check("t3_idle_after_high", rxBusy, 0);
    expQ.push_back(8'hA5);
    sendByte(8'hA5, 1'b1);
    idle(CPB);
    check("t3_good_after_err", expQ.size(), 0);
    check("t3_frame_err_total", feCnt, 1);

    // 4: consumer stalled, fifth byte overruns a 4-deep FIFO
    rdEn = 1'b0;
    for (int b = 8'h10; b <= 8'h13; b++) begin
      expQ.push_back(8'(b));
      sendByte(8'(b), 1'b1);
    end
    idle(CPB);
    check("t4_no_overrun_yet", ovCnt, 0);
    check("t4_head_valid", rxValid, 1);
    check("t4_head_byte", dout, 8'h10);
    sendByte(8'h14, 1'b1);
    idle(CPB);
    check("t4_overrun_once", ovCnt, 1);
    check("t4_no_frame_err", feCnt, 1);
    for (int i = 0; i < 4; i++) begin
      rdEn = 1'b1;
      idle(1);
      rdEn = 1'b0;
      idle(2);
    end
    check("t4_drained", rxValid, 0);
    check("t4_queue_empty", expQ.size(), 0);
    // rd_en on an empty FIFO must not change anything
    rdEn = 1'b1;
    idle(5);
    check("t4_pop_empty", rxValid, 0);

    // 5: reset in the middle of 0x3C's data bits
    rxP = 1'b0;
    bitTime();
    rxP = 1'b0;  // bit0 of 0x3C
    bitTime();
    rxP = 1'b0;  // bit1
    bitTime();
    rxP = 1'b1;  // bit2
    idle(CPB / 2);
    check("t5_busy_before_rst", rxBusy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_outputs_in_rst", {dout, rxValid, rxBusy, frameErr, overrun}, 32'h0);
    idle(3);
    rxP = 1'b1;
    rst = 1'b0;
    idle(2 * CPB);
    check("t5_nothing_pushed", rxValid, 0);
    expQ.push_back(8'hC3);
    sendByte(8'hC3, 1'b1);
    idle(CPB);
    check("t5_after_reset_rx", expQ.size(), 0);
    check("t5_flag_totals", feCnt * 16 + ovCnt, 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
